// File: rtl/pdata_ctrl.sv
// Host-side sequencer for one serial multiply-accumulate element: streams operands in,
// issues execute, and gathers the serial accumulator readout into a parallel result.
module pdata_ctrl #(
    parameter int unsigned SIZE  = 32,
    localparam int unsigned CNT_W = $clog2(4 * SIZE) + 1
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                start,
    input  logic [1:0]          cmd,
    input  logic                read_after,
    input  logic [SIZE-1:0]     a_in,
    input  logic [SIZE-1:0]     b_in,
    input  logic [4*SIZE-1:0]   acc_in,
    output logic                busy,
    output logic                done,
    output logic [4*SIZE-1:0]   result,
    output logic [2:0]          pe_opcode,
    output logic                pe_rx,
    input  logic                pe_tx
);

    localparam int unsigned W = 4 * SIZE;

    localparam logic [1:0] CmdMul     = 2'd0;
    localparam logic [1:0] CmdMac     = 2'd1;
    localparam logic [1:0] CmdRead    = 2'd2;
    localparam logic [1:0] CmdLoadAcc = 2'd3;

    localparam logic [2:0] OpShiftD1  = 3'd0;
    localparam logic [2:0] OpShiftD2  = 3'd1;
    localparam logic [2:0] OpShiftRes = 3'd2;
    localparam logic [2:0] OpLoadRes  = 3'd4;
    localparam logic [2:0] OpMul      = 3'd5;
    localparam logic [2:0] OpMulAdd   = 3'd6;
    localparam logic [2:0] OpNoOp     = 3'd7;

    localparam logic [CNT_W-1:0] LastOperandBit = CNT_W'(SIZE - 1);
    localparam logic [CNT_W-1:0] LastWordBit    = CNT_W'(W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StExec,
        StRead,
        StLoadAcc,
        StDone
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cmd_q;
    logic             read_after_q;
    logic [SIZE-1:0]  a_q;
    logic [SIZE-1:0]  b_q;
    logic [W-1:0]     acc_q;
    logic [W-1:0]     shreg_q;

    // Shadow operands are shifted in place so the next serial bit is always at a fixed index.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            cmd_q        <= CmdMul;
            read_after_q <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            shreg_q      <= '0;
            result       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pe_opcode    <= OpNoOp;
            pe_rx        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pe_opcode <= OpNoOp;
                    pe_rx     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        cmd_q        <= cmd;
                        read_after_q <= read_after;
                        a_q          <= a_in;
                        b_q          <= b_in;
                        acc_q        <= acc_in;
                        cnt_q        <= '0;
                        busy         <= 1'b1;
                        unique case (cmd)
                            CmdMul, CmdMac: begin
                                state_q   <= StLoadA;
                                pe_opcode <= OpShiftD1;
                                pe_rx     <= a_in[0];
                            end
                            CmdRead: begin
                                state_q   <= StRead;
                                pe_opcode <= OpShiftRes;
                                pe_rx     <= 1'b0;
                            end
                            default: begin
                                state_q   <= StLoadAcc;
                                pe_opcode <= OpLoadRes;
                                pe_rx     <= acc_in[W-1];
                            end
                        endcase
                    end
                end

                StLoadA: begin
                    if (cnt_q == LastOperandBit) begin
                        state_q   <= StLoadB;
                        cnt_q     <= '0;
                        pe_opcode <= OpShiftD2;
                        pe_rx     <= b_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        a_q   <= a_q >> 1;
                        pe_rx <= a_q[1];
                    end
                end

                StLoadB: begin
                    if (cnt_q == LastOperandBit) begin
                        state_q   <= StExec;
                        cnt_q     <= '0;
                        pe_opcode <= (cmd_q == CmdMac) ? OpMulAdd : OpMul;
                        pe_rx     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        b_q   <= b_q >> 1;
                        pe_rx <= b_q[1];
                    end
                end

                StExec: begin
                    cnt_q <= '0;
                    pe_rx <= 1'b0;
                    if (read_after_q) begin
                        state_q   <= StRead;
                        pe_opcode <= OpShiftRes;
                    end else begin
                        state_q   <= StDone;
                        pe_opcode <= OpNoOp;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end

                StRead: begin
                    // The element presents its accumulator LSB first.
                    shreg_q <= {pe_tx, shreg_q[W-1:1]};
                    pe_rx   <= 1'b0;
                    if (cnt_q == LastWordBit) begin
                        result    <= {pe_tx, shreg_q[W-1:1]};
                        state_q   <= StDone;
                        cnt_q     <= '0;
                        pe_opcode <= OpNoOp;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                StLoadAcc: begin
                    if (cnt_q == LastWordBit) begin
                        state_q   <= StDone;
                        cnt_q     <= '0;
                        pe_opcode <= OpNoOp;
                        pe_rx     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        acc_q <= acc_q << 1;
                        pe_rx <= acc_q[W-2];
                    end
                end

                StDone: begin
                    state_q   <= StIdle;
                    pe_opcode <= OpNoOp;
                    pe_rx     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end

                default: begin
                    state_q   <= StIdle;
                    pe_opcode <= OpNoOp;
                    pe_rx     <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
